// File: rtl/mem_ring_arbiter_pkg.sv
// Shared types and defaults for the ring-buffer memory arbiter: requester count,
// bus widths, per-requester address windows and the access FSM state encoding.
package mem_ring_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int AW        = 16;
  localparam int DW        = 16;

  // Entry i is the inclusive window of requester i.
  localparam logic [3:0][AW-1:0] DEF_WIN_START = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
  localparam logic [3:0][AW-1:0] DEF_WIN_END   = {16'h00FF, 16'h00BF, 16'h007F, 16'h003F};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Index width that stays legal for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ring_arbiter_rr_priority_select.sv
// Round-robin pick: first asserted request found searching upward from last+1,
// wrapping modulo N_REQ.
module rr_priority_select
  import mem_ring_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]          req,
  input  logic [idx_w(N_REQ)-1:0]   last,
  output logic [idx_w(N_REQ)-1:0]   winner,
  output logic                      valid
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = last;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IW'((int'(last) + i) % N_REQ);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ring_arbiter.sv
// Shares one memory port among N_REQ ring-buffer requesters, one access at a time,
// with round-robin grant and per-requester address window checking. READ_LATENCY >= 2.
module mem_ring_arbiter
  import mem_ring_arbiter_pkg::*;
#(
  parameter int                        N_REQ        = N_REQ_DEF,
  parameter int                        READ_LATENCY = 2,
  parameter logic [N_REQ-1:0][AW-1:0]  WIN_START    = DEF_WIN_START,
  parameter logic [N_REQ-1:0][AW-1:0]  WIN_END      = DEF_WIN_END
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            wr,
  input  logic [N_REQ-1:0][AW-1:0]    addr,
  input  logic [N_REQ-1:0][DW-1:0]    wdata,
  output logic [N_REQ-1:0]            done,
  output logic [N_REQ-1:0]            err,
  output logic [DW-1:0]               rdata,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wdata,
  output logic                        mem_wr,
  output logic                        mem_rd,
  input  logic [DW-1:0]               mem_rdata
);

  localparam int            IW       = idx_w(N_REQ);
  localparam int            CW       = idx_w(READ_LATENCY - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 2);

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, win_q, sel_idx;
  logic          sel_valid;
  logic          wr_q;
  logic [CW-1:0] cnt_q;
  logic          in_win;

  rr_priority_select #(.N_REQ(N_REQ)) u_select (
    .req    (req),
    .last   (last_q),
    .winner (sel_idx),
    .valid  (sel_valid)
  );

  // mem_addr doubles as the latched request address.
  assign in_win = (mem_addr >= WIN_START[win_q]) && (mem_addr <= WIN_END[win_q]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid) state_d = ISSUE;
      ISSUE:   state_d = (!in_win || wr_q) ? DONE : WAIT;
      WAIT:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    done   = '0;
    err    = '0;
    case (state_q)
      ISSUE: begin
        mem_wr = in_win &&  wr_q;
        mem_rd = in_win && !wr_q;
      end
      DONE: begin
        done[win_q] = 1'b1;
        err[win_q]  = !in_win;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= IW'(N_REQ - 1);
      win_q     <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: if (sel_valid) begin
          win_q     <= sel_idx;
          wr_q      <= wr[sel_idx];
          mem_addr  <= addr[sel_idx];
          mem_wdata <= wdata[sel_idx];
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (cnt_q == CNT_LAST) rdata <= mem_rdata;
          else                   cnt_q <= cnt_q + 1'b1;
        end
        DONE:    last_q <= win_q;
        default: ;
      endcase
    end
  end

endmodule
